instr_fetch_unit: RTL and testbench

Instruction fetch unit for the MIPS-32 core: holds the PC, fetches words from instruction memory over a req/ack handshake and presents the instruction register to the opcode decoder. It is the producer of the decoder's `op_code` input and the consumer of its `jump`/`beq` outputs. It computes the next PC from those outputs plus the ALU `zero` flag. It runs as a fetch/execute sequencer, with a minimum of 2 cycles per instruction.

---
 rtl/instr_fetch_unit.sv | 123 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: MIPS-32 PC holder and fetch/execute sequencer feeding the opcode decoder.
//
// Optional feature macro: IFU_BUS_TIMEOUT_EN
//   When defined, a fetch that waits TIMEOUT_CYCLES cycles without imem_ack
//   moves the unit to HALT and sets the sticky fetch_err. When it is undefined,
//   FETCH waits indefinitely and fetch_err is tied to 0.
//
// Ports:
//   clk, rst_n              clock; synchronous active-low reset
//   imem_req, imem_addr     fetch request and address (address always equals pc)
//   imem_ack, imem_rdata    memory handshake; rdata is valid while ack is high
//   stall                   holds the current instruction in EXEC
//   jump, beq, zero         decoder branch controls and ALU zero flag
//   instr, op_code          instruction register and its opcode field
//   instr_valid             instr is executing this cycle
//   pc, pc_plus4            address of instr and that address plus 4
//   illegal_op              opcode not decodable (EXEC cycles only)
//   instr_count             retired-instruction counter (wraps)
//   fetch_err               sticky bus timeout flag
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        jump,
    input  logic        beq,
    input  logic        zero,
    output logic [31:0] instr,
    output logic [5:0]  op_code,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        illegal_op,
    output logic [31:0] instr_count,
    output logic        fetch_err
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    state_t      state, state_nxt;
    logic [29:0] pc_word, next_word, jump_word, branch_word;
    logic        legal, timeout;

    // pc is stored as a word address so its low two bits are hardwired to 00.
    assign pc        = {pc_word, 2'b00};
    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;
    assign op_code   = instr[31:26];
    assign legal     = op_code inside {6'b000000, 6'b000010, 6'b101011,
                                       6'b000100, 6'b001000, 6'b100011};

    assign jump_word   = {pc_plus4[31:28], instr[25:0]};
    assign branch_word = pc_plus4[31:2] + {{14{instr[15]}}, instr[15:0]};
    // Decoder controls are don't-care for undecodable opcodes, so they are gated by legal first.
    assign next_word   = !legal        ? pc_plus4[31:2] :
                         jump          ? jump_word      :
                         (beq && zero) ? branch_word    : pc_plus4[31:2];

`ifdef IFU_BUS_TIMEOUT_EN
    logic [7:0] wait_cnt;
    // wait_cnt holds the number of earlier ack-less cycles in the current fetch.
    assign timeout   = !imem_ack && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
    assign fetch_err = (state == HALT);
    always_ff @(posedge clk) begin
        if (!rst_n || state != FETCH)
            wait_cnt <= 8'd0;
        else if (!imem_ack)
            wait_cnt <= wait_cnt + 8'd1;
    end
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout   = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        illegal_op  = 1'b0;
        unique case (state)
            IDLE:  state_nxt = FETCH;
            FETCH: begin
                imem_req  = 1'b1;
                state_nxt = imem_ack ? EXEC : timeout ? HALT : FETCH;
            end
            EXEC:  begin
                instr_valid = 1'b1;
                illegal_op  = !legal;
                state_nxt   = stall ? EXEC : FETCH;
            end
            default: state_nxt = HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_word     <= RESET_PC[31:2];
            instr       <= 32'd0;
            instr_count <= 32'd0;
        end else begin
            if (state == FETCH && imem_ack)
                instr <= imem_rdata;
            if (state == EXEC && !stall) begin
                pc_word     <= next_word;
                instr_count <= instr_count + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: self-checking bench for instr_fetch_unit against a PC/count reference model.
module tb_instr_fetch_unit;
    logic        clk = 1'b0, rst_n = 1'b0, imem_ack = 1'b0, stall = 1'b0;
    logic        jump = 1'b0, beq = 1'b0, zero = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_req, instr_valid, illegal_op, fetch_err;
    logic [31:0] imem_addr, instr, pc, pc_plus4, instr_count;
    logic [5:0]  op_code;

    int          tests = 0, fails = 0;
    logic [31:0] m_pc, m_cnt;

    instr_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .jump(jump),
        .beq(beq), .zero(zero), .instr(instr), .op_code(op_code),
        .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
        .illegal_op(illegal_op), .instr_count(instr_count), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    function automatic bit is_legal(input logic [31:0] w);
        logic [5:0] op;
        op = w[31:26];
        return op == 6'd0 || op == 6'd2 || op == 6'd43 || op == 6'd4 || op == 6'd8 || op == 6'd35;
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                               input logic j, input logic b, input logic z);
        logic [31:0] p4;
        int          off;
        p4 = p + 32'd4;
        if (!is_legal(w)) return p4;
        if (j === 1'b1) return (p4 & 32'hF000_0000) + (w & 32'h03FF_FFFF) * 4;
        off = $signed(w[15:0]);
        if (b === 1'b1 && z === 1'b1) return p4 + off * 4;
        return p4;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 40 && !imem_req; i++) step();
        if (!imem_req) begin
            tests++; fails++;
            $display("FAIL wait_req: imem_req=%b required 1", imem_req);
        end
    endtask

    task automatic issue(input logic [31:0] w, input int delay);
        wait_req();
        for (int i = 0; i < delay; i++) begin
            stall = 1'($urandom_range(0, 1));
            step();
        end
        stall = 1'($urandom_range(0, 1));
        imem_rdata = w;
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        stall = 1'b0;
        imem_rdata = $urandom;
    endtask

    task automatic retire(input logic [31:0] w, input logic j, input logic b, input logic z);
        jump = j; beq = b; zero = z; stall = 1'b0;
        step();
        m_pc = model_next(m_pc, w, j, b, z);
        m_cnt = m_cnt + 32'd1;
        jump = 1'b0; beq = 1'b0; zero = 1'b0;
    endtask

    task automatic goto_pc(input logic [31:0] target);
        logic [31:0] w;
        w = 32'h0800_0000 | ((target >> 2) & 32'h03FF_FFFF);
        issue(w, 0);
        retire(w, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        repeat (3) step();
        tests++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || illegal_op !== 1'b0 || fetch_err !== 1'b0) begin
            fails++; $display("FAIL reset_flags: req=%b valid=%b ill=%b err=%b required 0000", imem_req, instr_valid, illegal_op, fetch_err);
        end
        tests++; if (pc !== 32'h0 || pc_plus4 !== 32'h4 || instr !== 32'h0 || op_code !== 6'h0 || instr_count !== 32'h0) begin
            fails++; $display("FAIL reset_regs: pc=%h pc4=%h instr=%h op=%h cnt=%h", pc, pc_plus4, instr, op_code, instr_count);
        end
        rst_n = 1'b1;
        tests++; if (imem_req !== 1'b0) begin
            fails++; $display("FAIL first_cycle_req: imem_req=%b required 0", imem_req);
        end
        step();
        imem_ack = 1'b0;
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_count !== 32'h0) begin
            fails++; $display("FAIL second_cycle: req=%b addr=%h cnt=%h required 1 0 0", imem_req, imem_addr, instr_count);
        end
        tests++; if (instr !== 32'h0) begin
            fails++; $display("FAIL idle_ack_ignored: instr=%h required 0", instr);
        end
        m_pc = 32'h0; m_cnt = 32'h0;
    endtask

    task automatic test_sequential();
        issue(32'h2008_0005, 0);
        tests++; if (op_code !== 6'b001000 || instr_valid !== 1'b1 || illegal_op !== 1'b0 || instr !== 32'h2008_0005) begin
            fails++; $display("FAIL seq_exec: op=%b valid=%b ill=%b instr=%h", op_code, instr_valid, illegal_op, instr);
        end
        retire(32'h2008_0005, 1'b0, 1'b0, 1'b0);
        tests++; if (imem_addr !== 32'h4 || instr_count !== 32'h1 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
            fails++; $display("FAIL seq_next: addr=%h cnt=%h req=%b valid=%b required 4 1 1 0", imem_addr, instr_count, imem_req, instr_valid);
        end
    endtask

    task automatic test_beq();
        logic [31:0] words [3] = '{32'h1000_0003, 32'h1000_FFFF, 32'h1000_0003};
        logic        zs    [3] = '{1'b1, 1'b1, 1'b0};
        logic [31:0] exps  [3] = '{32'h20, 32'h10, 32'h14};
        for (int i = 0; i < 3; i++) begin
            goto_pc(32'h10);
            issue(words[i], 0);
            tests++; if (pc !== 32'h10) begin
                fails++; $display("FAIL beq_pc_%0d: pc=%h required 10", i, pc);
            end
            retire(words[i], 1'b0, 1'b1, zs[i]);
            tests++; if (imem_addr !== exps[i] || imem_addr !== m_pc) begin
                fails++; $display("FAIL beq_target_%0d: addr=%h required %h", i, imem_addr, exps[i]);
            end
        end
    endtask

    task automatic test_jump();
        goto_pc(32'h40);
        issue(32'h0800_0100, 0);
        retire(32'h0800_0100, 1'b1, 1'b1, 1'b1);
        tests++; if (imem_addr !== 32'h400) begin
            fails++; $display("FAIL jump_wins: addr=%h required 400", imem_addr);
        end
        goto_pc(32'h0);
        issue(32'h1000_FFFE, 0);
        retire(32'h1000_FFFE, 1'b0, 1'b1, 1'b1);
        tests++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
            fails++; $display("FAIL wrap_pc: pc=%h pc4=%h required fffffffc 0", pc, pc_plus4);
        end
        issue(32'h2008_0001, 0);
        retire(32'h2008_0001, 1'b0, 1'b0, 1'b0);
        tests++; if (imem_addr !== 32'h0 || instr_count !== m_cnt) begin
            fails++; $display("FAIL wrap_next: addr=%h cnt=%h required 0 %h", imem_addr, instr_count, m_cnt);
        end
    endtask

    task automatic test_stall_illegal();
        issue(32'h8C01_0000, 1);
        stall = 1'b1; imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++; if (pc !== m_pc || instr !== 32'h8C01_0000 || instr_count !== m_cnt || imem_req !== 1'b0 || instr_valid !== 1'b1) begin
                fails++; $display("FAIL stall_hold_%0d: pc=%h instr=%h cnt=%h req=%b valid=%b", i, pc, instr, instr_count, imem_req, instr_valid);
            end
        end
        imem_ack = 1'b0;
        retire(32'h8C01_0000, 1'b0, 1'b0, 1'b0);
        tests++; if (imem_addr !== m_pc || instr_count !== m_cnt) begin
            fails++; $display("FAIL stall_release: addr=%h cnt=%h required %h %h", imem_addr, instr_count, m_pc, m_cnt);
        end
        issue(32'hFC00_1234, 0);
        tests++; if (illegal_op !== 1'b1 || instr_valid !== 1'b1) begin
            fails++; $display("FAIL illegal_flag: ill=%b valid=%b required 1 1", illegal_op, instr_valid);
        end
        jump = 1'bz; beq = 1'bz; zero = 1'b1; stall = 1'b0;
        step();
        m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
        jump = 1'b0; beq = 1'b0; zero = 1'b0;
        tests++; if (imem_addr !== m_pc || illegal_op !== 1'b0) begin
            fails++; $display("FAIL illegal_next: addr=%h ill=%b required %h 0", imem_addr, illegal_op, m_pc);
        end
    endtask

    task automatic test_random();
        logic [5:0]  legal_ops [6] = '{6'd0, 6'd2, 6'd43, 6'd4, 6'd8, 6'd35};
        logic [31:0] w;
        logic        j, b, z;
        int          sc;
        for (int n = 0; n < 40; n++) begin
            w = $urandom;
            if ($urandom_range(0, 1) == 1) w[31:26] = legal_ops[$urandom_range(0, 5)];
            issue(w, $urandom_range(0, 3));
            tests++; if (instr !== w || instr_valid !== 1'b1 || illegal_op !== !is_legal(w) || pc !== m_pc) begin
                fails++; $display("FAIL rand_exec_%0d: instr=%h valid=%b ill=%b pc=%h required %h 1 %b %h", n, instr, instr_valid, illegal_op, pc, w, !is_legal(w), m_pc);
            end
            sc = $urandom_range(0, 2);
            for (int s = 0; s < sc; s++) begin
                stall = 1'b1; imem_ack = 1'($urandom_range(0, 1));
                jump = 1'($urandom_range(0, 1)); beq = 1'($urandom_range(0, 1));
                step();
            end
            imem_ack = 1'b0;
            j = 1'($urandom_range(0, 1)); b = 1'($urandom_range(0, 1)); z = 1'($urandom_range(0, 1));
            retire(w, j, b, z);
            tests++; if (imem_addr !== m_pc || instr_count !== m_cnt) begin
                fails++; $display("FAIL rand_next_%0d: addr=%h cnt=%h required %h %h", n, imem_addr, instr_count, m_pc, m_cnt);
            end
        end
    endtask

    task automatic test_timeout();
        rst_n = 1'b0; imem_ack = 1'b0; stall = 1'b0;
        step();
        rst_n = 1'b1;
        step();
`ifdef IFU_BUS_TIMEOUT_EN
        repeat (15) step();
        tests++; if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin
            fails++; $display("FAIL timeout_16th: req=%b err=%b required 1 0", imem_req, fetch_err);
        end
        step();
        tests++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            fails++; $display("FAIL timeout_17th: err=%b req=%b valid=%b required 1 0 0", fetch_err, imem_req, instr_valid);
        end
        imem_ack = 1'b1;
        repeat (4) step();
        imem_ack = 1'b0;
        tests++; if (fetch_err !== 1'b1 || imem_req !== 1'b0) begin
            fails++; $display("FAIL halt_sticky: err=%b req=%b required 1 0", fetch_err, imem_req);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        tests++; if (fetch_err !== 1'b0 || imem_req !== 1'b0) begin
            fails++; $display("FAIL halt_reset: err=%b req=%b required 0 0", fetch_err, imem_req);
        end
        step();
        tests++; if (imem_req !== 1'b1) begin
            fails++; $display("FAIL halt_recover: req=%b required 1", imem_req);
        end
`else
        repeat (40) step();
        tests++; if (imem_req !== 1'b1 || fetch_err !== 1'b0 || imem_addr !== 32'h0) begin
            fails++; $display("FAIL no_timeout: req=%b err=%b addr=%h required 1 0 0", imem_req, fetch_err, imem_addr);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_beq();
        test_jump();
        test_stall_illegal();
        test_random();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
